// File: rtl/pc_pkg.sv
// Shared types and defaults for the IF-stage program-counter unit.
package pc_pkg;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BRANCH,
    SRC_RET,
    SRC_FLUSH,
    SRC_HOLD
  } pc_src_e;

  localparam int unsigned                PC_ADDR_W_DEF     = 8;
  localparam logic [PC_ADDR_W_DEF-1:0]   PC_RESET_ADDR_DEF = 8'h00;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full;
// overflow/underflow are registered one-cycle pulses.
module pc_ras import pc_pkg::*; #(
  parameter int unsigned ADDR_W = PC_ADDR_W_DEF,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, rd_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              of_q, of_d, uf_q, uf_d;

  // wp_q is the next slot to write; when full it also indexes the oldest entry.
  assign rd_idx      = wp_q - PTR_W'(1);
  assign top_o       = mem_q[rd_idx];
  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == DEPTH_C);
  assign overflow_o  = of_q;
  assign underflow_o = uf_q;

  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    of_d  = 1'b0;
    uf_d  = 1'b0;
    if (push_i) begin
      wp_d = wp_q + PTR_W'(1);
      if (full_o) of_d  = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i) begin
      if (empty_o) begin
        uf_d = 1'b1;
      end else begin
        wp_d  = rd_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      if (push_i) mem_q[wp_q] <= push_data_i;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// IF-stage program counter with stall, branch/flush redirect and optional
// return-address stack (enabled by defining PC_RAS_EN).
module pc_seq_unit import pc_pkg::*; #(
  parameter int unsigned       ADDR_W     = PC_ADDR_W_DEF,
  parameter int unsigned       INC        = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(PC_RESET_ADDR_DEF),
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush_valid,
  input  logic [ADDR_W-1:0] flush_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_underflow,
  output logic              ras_overflow
);

  localparam logic [ADDR_W-1:0] INC_W = ADDR_W'(INC);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_push, ras_pop;
  pc_src_e           src;

  assign pc      = pc_q;
  assign pc_plus = pc_q + INC_W;

`ifdef PC_RAS_EN
  pc_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus),
    .top_o       (ras_top),
    .empty_o     (ras_empty),
    .full_o      (ras_full),
    .overflow_o  (ras_overflow),
    .underflow_o (ras_underflow)
  );
`else
  // A permanently empty stack turns ret into a sequential step and call into a plain branch.
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_ras_req;
  assign unused_ras_req = ras_push | ras_pop;
  assign ras_top        = '0;
  assign ras_empty      = 1'b1;
  assign ras_full       = 1'b0;
  assign ras_overflow   = 1'b0;
  assign ras_underflow  = 1'b0;
`endif

  always_comb begin
    src      = SRC_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (flush_valid) begin
      src = SRC_FLUSH;
    end else if (stall) begin
      src = SRC_HOLD;
    end else if (ret) begin
      ras_pop = 1'b1;
      src     = ras_empty ? SRC_SEQ : SRC_RET;
    end else if (branch_taken) begin
      src      = SRC_BRANCH;
      ras_push = call;
    end
  end

  always_comb begin
    pc_d = pc_plus;
    unique case (src)
      SRC_FLUSH:  pc_d = flush_target;
      SRC_HOLD:   pc_d = pc_q;
      SRC_RET:    pc_d = ras_top;
      SRC_BRANCH: pc_d = branch_target;
      default:    pc_d = pc_plus;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= RESET_ADDR;
    else        pc_q <= pc_d;
  end

endmodule

// File: tb/tb_pc_seq_unit.sv
// Directed and randomized checks of pc_seq_unit against a queue-based model.
module tb_pc_seq_unit;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned INC        = 1;
  localparam logic [7:0]  RESET_ADDR = 8'h00;
  localparam int unsigned RAS_DEPTH  = 4;
  localparam int unsigned MASK       = (1 << ADDR_W) - 1;
`ifdef PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic       clk, reset, stall, flush_valid, branch_taken, call, ret;
  logic [7:0] flush_target, branch_target, pc, pc_plus;
  logic       ras_empty, ras_full, ras_underflow, ras_overflow;

  int checks   = 0;
  int failures = 0;

  int unsigned pc_m;
  int unsigned ras_m[$];
  bit          uf_m, of_m;

  pc_seq_unit #(
    .ADDR_W     (ADDR_W),
    .INC        (INC),
    .RESET_ADDR (RESET_ADDR),
    .RAS_DEPTH  (RAS_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush_valid   (flush_valid),
    .flush_target  (flush_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .call          (call),
    .ret           (ret),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_underflow (ras_underflow),
    .ras_overflow  (ras_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pc_m = RESET_ADDR;
    ras_m.delete();
    uf_m = 1'b0;
    of_m = 1'b0;
  endtask

  // Applies the redirect priority rules to the inputs currently driven.
  task automatic model_step();
    uf_m = 1'b0;
    of_m = 1'b0;
    if (flush_valid) begin
      pc_m = flush_target;
    end else if (stall) begin
      pc_m = pc_m;
    end else if (ret) begin
      if (RAS_EN && ras_m.size() > 0) begin
        pc_m = ras_m.pop_back();
      end else begin
        pc_m = (pc_m + INC) & MASK;
        uf_m = RAS_EN;
      end
    end else if (branch_taken) begin
      if (RAS_EN && call) begin
        if (ras_m.size() == RAS_DEPTH) begin
          void'(ras_m.pop_front());
          of_m = 1'b1;
        end
        ras_m.push_back((pc_m + INC) & MASK);
      end
      pc_m = branch_target;
    end else begin
      pc_m = (pc_m + INC) & MASK;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, "_pc"},      pc,            pc_m);
    chk({ctx, "_pc_plus"}, pc_plus,       (pc_m + INC) & MASK);
    chk({ctx, "_empty"},   ras_empty,     ras_m.size() == 0);
    chk({ctx, "_full"},    ras_full,      ras_m.size() == RAS_DEPTH);
    chk({ctx, "_uflow"},   ras_underflow, uf_m);
    chk({ctx, "_oflow"},   ras_overflow,  of_m);
  endtask

  task automatic cyc(input logic st, input logic fv, input logic [7:0] ft, input logic bt,
                     input logic [7:0] btg, input logic cl, input logic rt, input string ctx);
    stall = st; flush_valid = fv; flush_target = ft;
    branch_taken = bt; branch_target = btg; call = cl; ret = rt;
    model_step();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic clear_inputs();
    stall = 0; flush_valid = 0; flush_target = 0;
    branch_taken = 0; branch_target = 0; call = 0; ret = 0;
  endtask

  // Called 1 time unit after a rising edge; reset is pulsed without any clock edge.
  task automatic do_reset(input string ctx);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    chk({ctx, "_const_pc"}, pc, 8'h00);
    clear_inputs();
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    chk("reset_const_pc", pc, 8'h00);
    @(negedge clk) reset = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 8'h00, 0, 8'h00, 0, 0, "seq");
      chk("seq_const_pc", pc, i);
    end

    // Pending branch request is dropped by an asynchronous reset.
    branch_taken = 1'b1; branch_target = 8'h77;
    do_reset("async_reset");

    cyc(0, 1, 8'h10, 0, 8'h00, 0, 0, "to10");
    cyc(0, 0, 8'h00, 1, 8'h40, 0, 0, "branch");
    chk("branch_const_pc", pc, 8'h40);
    cyc(0, 0, 8'h00, 0, 8'h00, 0, 0, "after_branch");
    chk("after_branch_const_pc", pc, 8'h41);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 8'h00, 1, 8'h99, 0, 1, "stall");
      chk("stall_const_pc", pc, 8'h41);
    end
    cyc(1, 1, 8'h80, 1, 8'h99, 0, 0, "stall_flush");
    chk("stall_flush_const_pc", pc, 8'h80);

    do_reset("reset2");
    for (int i = 0; i < 5; i++) cyc(0, 0, 8'h00, 0, 8'h00, 0, 0, "to05");
    cyc(0, 0, 8'h00, 1, 8'h30, 1, 0, "call");
    chk("call_const_pc", pc, 8'h30);
    cyc(0, 0, 8'h00, 0, 8'h00, 0, 0, "to31");
    cyc(0, 0, 8'h00, 1, 8'h55, 0, 1, "ret");
`ifdef PC_RAS_EN
    chk("ret_const_pc", pc, 8'h06);
`else
    chk("ret_const_pc", pc, 8'h32);
`endif
    chk("ret_const_empty", ras_empty, 1'b1);

    do_reset("reset3");
    for (int k = 1; k <= 5; k++) cyc(0, 0, 8'h00, 1, 8'(k), 1, 0, "call_n");
`ifdef PC_RAS_EN
    chk("fifth_call_const_oflow", ras_overflow, 1'b1);
`endif
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 8'h00, 0, 8'h00, 0, 1, "ret_n");
`ifdef PC_RAS_EN
      chk("ret_n_const_pc", pc, 5 - k);
`endif
    end
    cyc(0, 0, 8'h00, 0, 8'h00, 0, 1, "ret_empty");
`ifdef PC_RAS_EN
    chk("ret_empty_const_uflow", ras_underflow, 1'b1);
    chk("ret_empty_const_pc", pc, 8'h03);
`endif
    cyc(0, 0, 8'h00, 0, 8'h00, 0, 0, "after_uflow");

    cyc(0, 1, 8'hFF, 0, 8'h00, 0, 0, "toFF");
    cyc(0, 0, 8'h00, 0, 8'h00, 0, 0, "wrap");
    chk("wrap_const_pc", pc, 8'h00);

    cyc(0, 1, 8'h20, 0, 8'h00, 0, 0, "to20");
    cyc(0, 0, 8'h00, 0, 8'h00, 0, 1, "ret20");
`ifndef PC_RAS_EN
    chk("noras_ret_const_pc", pc, 8'h21);
    chk("noras_ret_const_empty", ras_empty, 1'b1);
`endif

    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, 8'($urandom),
          $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 5) == 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
